// File: rtl/btb_pkg.sv
// ---------------------------------------------------------------------------
// btb_pkg
// Shared definitions for the BTB update path: default table geometry,
// 2-bit history counter action encodings, controller state type and the
// layout of one queued BTB update.
// ---------------------------------------------------------------------------
package btb_pkg;

  localparam int WORD_SIZE  = 16;
  localparam int IDX_BITS   = 8;
  localparam int FIFO_DEPTH = 4;

  // Counter actions presented to the history-counter array with each write.
  localparam logic [1:0] CNT_NONE = 2'b00;
  localparam logic [1:0] CNT_INC  = 2'b01;
  localparam logic [1:0] CNT_DEC  = 2'b10;
  localparam logic [1:0] CNT_CLR  = 2'b11;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } ctrlState_e;

  // One BTB update as seen by the table (default geometry).
  typedef struct packed {
    logic [WORD_SIZE-IDX_BITS-1:0] tag;
    logic [IDX_BITS-1:0]           idx;
    logic [WORD_SIZE-1:0]          target;
    logic [1:0]                    cntOp;
  } updEntry_t;

  // A resolved branch trains its counter toward its actual outcome.
  function automatic logic [1:0] exCntOp(input logic taken);
    return taken ? CNT_INC : CNT_DEC;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// ---------------------------------------------------------------------------
// btb_upd_fifo
// Small synchronous FIFO holding accepted BTB updates until the single BTB
// write port can take them.
// Ports:
//   i_clk       clock, all state on rising edge
//   i_clear     synchronous clear: empties the queue
//   i_push      write i_pushData at the tail (ignored when full)
//   i_pushData  entry to enqueue
//   i_pop       drop the head entry (ignored when empty)
//   o_full      occupancy equals DEPTH
//   o_empty     occupancy is zero
//   o_head      current head entry (valid when !o_empty)
// ---------------------------------------------------------------------------
module btb_upd_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W:0]   r_count;
  logic             w_doPush;
  logic             w_doPop;

  // Guard the handshakes locally so a misbehaving caller can never corrupt
  // the occupancy count.
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;

  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two; the explicit
  // count keeps full/empty purely registered so a same-cycle pop never
  // frees space for a push.
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_pushData;
        r_wrPtr        <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// ---------------------------------------------------------------------------
// btb_update_ctrl
// Sequences every write into the BTB and its 2-bit history counters. After
// reset or flush it sweeps all entries clearing them, then arbitrates ID
// (jump) and EX (resolved branch) updates into a queue that drains one BTB
// write per cycle.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_flush                 drop queued updates and restart the clear sweep
//   i_id_valid/pc/target    ID-stage jump update, o_id_ready handshake
//   i_ex_valid/pc/target    EX-stage branch update, o_ex_ready handshake
//   i_ex_taken              branch outcome, selects counter inc/dec
//   o_btb_we                BTB write strobe
//   o_btb_idx/tag/target    entry index, tag and target to store
//   o_btb_vld               valid bit to store (0 while sweeping)
//   o_cnt_op                history counter action for this write
//   o_busy                  clear sweep in progress
// ---------------------------------------------------------------------------
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int WORD_SIZE  = btb_pkg::WORD_SIZE,
  parameter int IDX_BITS   = btb_pkg::IDX_BITS,
  parameter int FIFO_DEPTH = btb_pkg::FIFO_DEPTH
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_flush,
  input  logic                          i_id_valid,
  input  logic [WORD_SIZE-1:0]          i_id_pc,
  input  logic [WORD_SIZE-1:0]          i_id_target,
  output logic                          o_id_ready,
  input  logic                          i_ex_valid,
  input  logic [WORD_SIZE-1:0]          i_ex_pc,
  input  logic [WORD_SIZE-1:0]          i_ex_target,
  input  logic                          i_ex_taken,
  output logic                          o_ex_ready,
  output logic                          o_btb_we,
  output logic [IDX_BITS-1:0]           o_btb_idx,
  output logic [WORD_SIZE-IDX_BITS-1:0] o_btb_tag,
  output logic [WORD_SIZE-1:0]          o_btb_target,
  output logic                          o_btb_vld,
  output logic [1:0]                    o_cnt_op
  ,output logic                         o_busy
);

  localparam int TAG_W   = WORD_SIZE - IDX_BITS;
  localparam int ENTRY_W = 2 * WORD_SIZE + 2;

  ctrlState_e            r_state;
  ctrlState_e            w_stateNext;
  logic [IDX_BITS-1:0]   r_sweepCnt;
  logic                  w_sweepLast;
  logic                  w_restart;
  logic                  w_canAccept;
  logic                  w_pushEx;
  logic                  w_pushId;
  logic                  w_push;
  logic [ENTRY_W-1:0]    w_pushData;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [ENTRY_W-1:0]    w_head;
  logic [WORD_SIZE-1:0]  w_headPc;
  logic [WORD_SIZE-1:0]  w_headTarget;
  logic [1:0]            w_headCntOp;

  logic                  r_we;
  logic [IDX_BITS-1:0]   r_idx;
  logic [TAG_W-1:0]      r_tag;
  logic [WORD_SIZE-1:0]  r_target;
  logic                  r_vld;
  logic [1:0]            r_cntOp;

  // Reset and flush both throw away all queued work and restart the sweep;
  // they also block this cycle's handshakes so nothing is accepted and lost.
  assign w_restart   = i_reset | i_flush;
  assign w_sweepLast = &r_sweepCnt;

  assign o_busy      = (r_state == S_CLEAR);
  assign w_canAccept = ~w_restart & ~o_busy & ~w_full;
  assign o_ex_ready  = w_canAccept;
  assign o_id_ready  = w_canAccept & ~i_ex_valid;

  assign w_pushEx = i_ex_valid & o_ex_ready;
  assign w_pushId = i_id_valid & o_id_ready;
  assign w_push   = w_pushEx | w_pushId;

  // The queue stores the raw PC; tag and index are split off on the way out.
  assign w_pushData = w_pushEx ? {i_ex_pc, i_ex_target, exCntOp(i_ex_taken)}
                               : {i_id_pc, i_id_target, CNT_NONE};

  assign w_pop = (r_state == S_RUN) & ~w_empty & ~w_restart;

  assign w_headPc     = w_head[ENTRY_W-1 -: WORD_SIZE];
  assign w_headTarget = w_head[WORD_SIZE+1 -: WORD_SIZE];
  assign w_headCntOp  = w_head[1:0];

  btb_upd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_clear    (w_restart),
    .i_push     (w_push),
    .i_pushData (w_pushData),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head     (w_head)
  );

  // State register; reset is sampled here, flush is folded into next state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // The sweep leaves CLEAR on the same edge that loads the last index, so
  // busy falls while that final clear write is being presented.
  always_comb begin
    w_stateNext = r_state;
    if (i_flush) begin
      w_stateNext = S_CLEAR;
    end else if ((r_state == S_CLEAR) && w_sweepLast) begin
      w_stateNext = S_RUN;
    end
  end

  // Sweep index; it only advances while clearing and leaves the state machine
  // at the terminal index, so it never walks past the last entry.
  always_ff @(posedge i_clk) begin
    if (w_restart) begin
      r_sweepCnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_sweepCnt <= r_sweepCnt + 1'b1;
    end
  end

  // Registered BTB write port. Sweep writes invalidate an entry and reset its
  // counter; in RUN the queue head is written with the valid bit set. Idle
  // cycles drive all fields to zero so stale data never sits on the port.
  always_ff @(posedge i_clk) begin
    if (w_restart) begin
      r_we     <= 1'b0;
      r_idx    <= '0;
      r_tag    <= '0;
      r_target <= '0;
      r_vld    <= 1'b0;
      r_cntOp  <= CNT_NONE;
    end else if (r_state == S_CLEAR) begin
      r_we     <= 1'b1;
      r_idx    <= r_sweepCnt;
      r_tag    <= '0;
      r_target <= '0;
      r_vld    <= 1'b0;
      r_cntOp  <= CNT_CLR;
    end else if (w_pop) begin
      r_we     <= 1'b1;
      r_idx    <= w_headPc[IDX_BITS-1:0];
      r_tag    <= w_headPc[WORD_SIZE-1:IDX_BITS];
      r_target <= w_headTarget;
      r_vld    <= 1'b1;
      r_cntOp  <= w_headCntOp;
    end else begin
      r_we     <= 1'b0;
      r_idx    <= '0;
      r_tag    <= '0;
      r_target <= '0;
      r_vld    <= 1'b0;
      r_cntOp  <= CNT_NONE;
    end
  end

  assign o_btb_we     = r_we;
  assign o_btb_idx    = r_idx;
  assign o_btb_tag    = r_tag;
  assign o_btb_target = r_target;
  assign o_btb_vld    = r_vld;
  assign o_cnt_op     = r_cntOp;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_btb_update_ctrl
// Directed bench for btb_update_ctrl with a queue-based reference model of
// the update path and a per-cycle compare process.
// ---------------------------------------------------------------------------
module tb_btb_update_ctrl;
  import btb_pkg::*;

  localparam int WS = btb_pkg::WORD_SIZE;
  localparam int IB = btb_pkg::IDX_BITS;
  localparam int NUM_ENTRIES = 1 << IB;
  localparam int DEPTH = btb_pkg::FIFO_DEPTH;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          idValid;
  logic [WS-1:0] idPc;
  logic [WS-1:0] idTarget;
  logic          idReady;
  logic          exValid;
  logic [WS-1:0] exPc;
  logic [WS-1:0] exTarget;
  logic          exTaken;
  logic          exReady;
  logic          btbWe;
  logic [IB-1:0] btbIdx;
  logic [WS-IB-1:0] btbTag;
  logic [WS-1:0] btbTarget;
  logic          btbVld;
  logic [1:0]    cntOp;
  logic          busy;

  int total = 0;
  int bad   = 0;

  btb_update_ctrl dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_flush      (flush),
    .i_id_valid   (idValid),
    .i_id_pc      (idPc),
    .i_id_target  (idTarget),
    .o_id_ready   (idReady),
    .i_ex_valid   (exValid),
    .i_ex_pc      (exPc),
    .i_ex_target  (exTarget),
    .i_ex_taken   (exTaken),
    .o_ex_ready   (exReady),
    .o_btb_we     (btbWe),
    .o_btb_idx    (btbIdx),
    .o_btb_tag    (btbTag),
    .o_btb_target (btbTarget),
    .o_btb_vld    (btbVld),
    .o_cnt_op     (cntOp),
    .o_busy       (busy)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: sweeping flag/index plus a queue of accepted updates.
  // It reacts to the same rising edge as the design, using the inputs held
  // across that edge, and yields what the write port must show afterwards.
  updEntry_t mQueue[$];
  bit        mOn = 0;
  bit        mClear = 1;
  int        mIdx = 0;
  bit        expWe = 0;
  bit        expVld = 0;
  bit        expZero = 0;
  updEntry_t expEnt;

  always @(posedge clk) begin
    bit        canPush;
    updEntry_t e;
    if (reset || flush) begin
      mOn = 1;
      mClear = 1;
      mIdx = 0;
      mQueue.delete();
      expWe = 0;
      expVld = 0;
      expZero = 1;
    end else if (mClear) begin
      expWe = 1;
      expVld = 0;
      expZero = 0;
      expEnt.tag = '0;
      expEnt.idx = mIdx[IB-1:0];
      expEnt.target = '0;
      expEnt.cntOp = 2'b11;
      if (mIdx == NUM_ENTRIES - 1) mClear = 0;
      mIdx++;
    end else begin
      canPush = (mQueue.size() < DEPTH);
      expZero = 0;
      if (mQueue.size() > 0) begin
        expEnt = mQueue.pop_front();
        expWe = 1;
        expVld = 1;
      end else begin
        expWe = 0;
        expVld = 0;
      end
      if (canPush && exValid) begin
        e.tag = exPc[WS-1:IB];
        e.idx = exPc[IB-1:0];
        e.target = exTarget;
        e.cntOp = exTaken ? 2'b01 : 2'b10;
        mQueue.push_back(e);
      end else if (canPush && idValid) begin
        e.tag = idPc[WS-1:IB];
        e.idx = idPc[IB-1:0];
        e.target = idTarget;
        e.cntOp = 2'b00;
        mQueue.push_back(e);
      end
    end
  end

  // Compare process: on every falling edge once the model is live.
  always @(negedge clk) begin
    bit rdy;
    if (mOn) begin
      rdy = !reset && !flush && !mClear && (mQueue.size() < DEPTH);
      checkOutput("we", btbWe, expWe);
      checkOutput("busy", busy, mClear);
      checkOutput("exReady", exReady, rdy);
      checkOutput("idReady", idReady, rdy && !exValid);
      if (expWe) begin
        checkOutput("idx", btbIdx, expEnt.idx);
        checkOutput("tag", btbTag, expEnt.tag);
        checkOutput("target", btbTarget, expEnt.target);
        checkOutput("vld", btbVld, expVld);
        checkOutput("cntOp", cntOp, expEnt.cntOp);
      end
      if (expZero) begin
        checkOutput("zeroIdx", btbIdx, 0);
        checkOutput("zeroTag", btbTag, 0);
        checkOutput("zeroTarget", btbTarget, 0);
        checkOutput("zeroVld", btbVld, 0);
        checkOutput("zeroCntOp", cntOp, 0);
      end
    end
  end

  // Drives one cycle of inputs shortly after a rising edge.
  task automatic applyStimulus(input bit rst, input bit fl,
                               input bit iv, input logic [WS-1:0] ipc, input logic [WS-1:0] itg,
                               input bit ev, input logic [WS-1:0] epc, input logic [WS-1:0] etg,
                               input bit et);
    @(posedge clk);
    #2;
    reset = rst;
    flush = fl;
    idValid = iv;
    idPc = ipc;
    idTarget = itg;
    exValid = ev;
    exPc = epc;
    exTarget = etg;
    exTaken = et;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, '0, '0, 0, '0, '0, 0);
  endtask

  initial begin
    int seen;
    bit found;
    reset = 1'b1;
    flush = 1'b0;
    idValid = 1'b0;
    idPc = '0;
    idTarget = '0;
    exValid = 1'b0;
    exPc = '0;
    exTarget = '0;
    exTaken = 1'b0;

    // Reset for two edges, then release and observe reset values.
    applyStimulus(1, 0, 0, '0, '0, 0, '0, '0, 0);
    idle();
    #1;
    checkOutput("lit_resetWe", btbWe, 0);
    checkOutput("lit_resetBusy", busy, 1);
    checkOutput("lit_resetExReady", exReady, 0);

    // Full clear sweep, one index per cycle.
    seen = 0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      idle();
      #1;
      if (btbWe === 1'b1 && btbIdx === i[IB-1:0] && btbVld === 1'b0 && cntOp === 2'b11) seen++;
    end
    checkOutput("lit_sweepWrites", seen, NUM_ENTRIES);
    checkOutput("lit_busyDropAtLast", busy, 0);

    // Single taken branch after the sweep.
    applyStimulus(0, 0, 0, '0, '0, 1, 16'h1234, 16'h1300, 1);
    #1;
    checkOutput("lit_idleAfterSweep", btbWe, 0);
    idle();
    #1;
    checkOutput("lit_noWriteYet", btbWe, 0);
    idle();
    #1;
    checkOutput("lit_exWe", btbWe, 1);
    checkOutput("lit_exIdx", btbIdx, 8'h34);
    checkOutput("lit_exTag", btbTag, 8'h12);
    checkOutput("lit_exTarget", btbTarget, 16'h1300);
    checkOutput("lit_exCnt", cntOp, 2'b01);
    checkOutput("lit_exVld", btbVld, 1);

    // ID and EX together: EX wins, ID held and taken next cycle.
    applyStimulus(0, 0, 1, 16'h2040, 16'h2100, 1, 16'h3050, 16'h3000, 0);
    #1;
    checkOutput("lit_idBlocked", idReady, 0);
    checkOutput("lit_exAccepted", exReady, 1);
    applyStimulus(0, 0, 1, 16'h2040, 16'h2100, 0, '0, '0, 0);
    #1;
    checkOutput("lit_idReadyNext", idReady, 1);
    idle();
    #1;
    checkOutput("lit_firstIsEx", btbIdx, 8'h50);
    checkOutput("lit_firstCnt", cntOp, 2'b10);
    idle();
    #1;
    checkOutput("lit_secondIsId", btbIdx, 8'h40);
    checkOutput("lit_secondCnt", cntOp, 2'b00);

    // Held not-taken EX stream; the model tracks order and occupancy.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, '0, '0, 1, 16'h4000 + 16'(i), 16'h5000 + 16'(i), 0);
    end
    // Mixed ID/EX traffic.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 1, 16'h6100 + 16'(i), 16'h7000, (i % 2) == 1, 16'h8200 + 16'(i), 16'h9000, 1);
    end

    // Flush with updates in flight: they must never be written.
    applyStimulus(0, 0, 0, '0, '0, 1, 16'hA0A1, 16'hB000, 1);
    applyStimulus(0, 1, 1, 16'hA1A2, 16'hB100, 1, 16'hA2A3, 16'hB200, 0);
    #1;
    checkOutput("lit_flushExReady", exReady, 0);
    checkOutput("lit_flushIdReady", idReady, 0);
    idle();
    #1;
    checkOutput("lit_flushWeLow", btbWe, 0);
    idle();
    #1;
    checkOutput("lit_sweepRestartWe", btbWe, 1);
    checkOutput("lit_sweepRestartIdx", btbIdx, 0);
    checkOutput("lit_sweepRestartVld", btbVld, 0);

    // Reset (with flush and a request) at sweep index 100.
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      idle();
      #1;
      if (btbIdx === 8'd100) found = 1;
    end
    checkOutput("lit_reachIdx100", found, 1);
    applyStimulus(1, 1, 0, '0, '0, 1, 16'hC0C0, 16'hD000, 1);
    #1;
    checkOutput("lit_resetExReady2", exReady, 0);
    idle();
    #1;
    checkOutput("lit_reset2We", btbWe, 0);
    checkOutput("lit_reset2Busy", busy, 1);
    idle();
    #1;
    checkOutput("lit_reset2Idx", btbIdx, 0);

    // Let the sweep finish, then a final short burst.
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      idle();
      #1;
      if (busy === 1'b0) found = 1;
    end
    checkOutput("lit_sweepDone", found, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 16'hE000 + 16'(i), 16'hF000 + 16'(i), 0, '0, '0, 0);
    end
    for (int i = 0; i < 4; i++) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
